// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared constants and FSM state encoding for the NPU sequencer
package npu_pkg;

    localparam int NPU_ROWS   = 4;
    localparam int NPU_COLS   = 4;
    localparam int NPU_LAT    = NPU_ROWS + NPU_COLS - 1;
    localparam int NPU_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } npu_state_e;

endpackage

// File: rtl/npu_valid_dly.sv
// rtl/npu_valid_dly.sv - LAT-deep valid delay line with synchronous flush
// Ports: clk, resetn (sync, active-low), flush (clears every stage),
//        din (valid in), dout (din delayed by exactly LAT cycles, registered).
module npu_valid_dly #(
    parameter int LAT = 7
) (
    input  logic clk,
    input  logic resetn,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] sr;

    if (LAT == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (!resetn || flush) begin
                sr <= '0;
            end else begin
                sr <= din;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (!resetn || flush) begin
                sr <= '0;
            end else begin
                sr <= {sr[LAT-2:0], din};
            end
        end
    end

    assign dout = sr[LAT-1];

endmodule

// File: rtl/npu_seq_ctrl.sv
// rtl/npu_seq_ctrl.sv - load/stream/drain sequencer for the 4x4 systolic NPU array
// Ports: wb_clk_i, wb_rst_ni (sync, active-low); start_i/abort_i/num_vec_i control;
//        busy_o/done_o status; w_rd_addr_o/w_load_o weight path; x_rd_addr_o/en_o
//        activation path; res_we_o/res_addr_o result path.
//        NPU_SEQ_PERF_EN adds perf_cyc_o (saturating busy-cycle counter).
module npu_seq_ctrl
    import npu_pkg::*;
#(
    parameter int ROWS   = NPU_ROWS,
    parameter int ADDR_W = NPU_ADDR_W,
    parameter int LAT    = NPU_LAT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] num_vec_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] w_rd_addr_o,
    output logic [ROWS-1:0]   w_load_o,
    output logic [ADDR_W-1:0] x_rd_addr_o,
    output logic              en_o,
    output logic              res_we_o,
    output logic [ADDR_W-1:0] res_addr_o
`ifdef NPU_SEQ_PERF_EN
    ,
    output logic [15:0]       perf_cyc_o
`endif
);

    localparam logic [ADDR_W-1:0] LOAD_LAST  = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(LAT);

    npu_state_e        state;
    npu_state_e        state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] n_q;

    logic              abort_act;
    logic              start_acc;

    logic              busy_d;
    logic              done_d;
    logic              w_vld_d;
    logic              x_vld_d;
    logic [ADDR_W-1:0] w_addr_d;
    logic [ADDR_W-1:0] x_addr_d;

    // Qualifiers travelling alongside the issued read addresses; they become
    // the strobes one cycle later when the buffer read data is valid.
    logic              w_vld_q;
    logic              x_vld_q;

    assign abort_act = abort_i && (state != ST_IDLE);
    assign start_acc = start_i && !abort_i && (state == ST_IDLE);

    // State register; cnt restarts at every state change so each state
    // simply counts its own cycles.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
            cnt   <= '0;
            n_q   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state || state_nx == ST_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ADDR_W'(1);
            end
            if (start_acc) begin
                n_q <= num_vec_i;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (abort_act) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_acc) state_nx = ST_LOAD;
                ST_LOAD:   if (cnt == LOAD_LAST)
                               state_nx = (n_q != '0) ? ST_STREAM : ST_DRAIN;
                ST_STREAM: if (cnt == n_q - ADDR_W'(1)) state_nx = ST_DRAIN;
                ST_DRAIN:  if (cnt == DRAIN_LAST) state_nx = ST_DONE;
                ST_DONE:   state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d   = (state != ST_IDLE);
        done_d   = (state == ST_DONE);
        w_vld_d  = (state == ST_LOAD);
        w_addr_d = w_vld_d ? cnt : '0;
        x_vld_d  = (state == ST_STREAM);
        x_addr_d = x_vld_d ? cnt : '0;
    end

    // Output registers. Abort clears everything on the same edge that
    // returns the FSM to IDLE, so nothing from the cancelled run leaks out.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || abort_act) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            w_rd_addr_o <= '0;
            w_vld_q     <= 1'b0;
            w_load_o    <= '0;
            x_rd_addr_o <= '0;
            x_vld_q     <= 1'b0;
            en_o        <= 1'b0;
            res_addr_o  <= '0;
        end else begin
            busy_o      <= busy_d;
            done_o      <= done_d;
            w_rd_addr_o <= w_addr_d;
            w_vld_q     <= w_vld_d;
            w_load_o    <= w_vld_q ? (ROWS'(1) << w_rd_addr_o) : '0;
            x_rd_addr_o <= x_addr_d;
            x_vld_q     <= x_vld_d;
            en_o        <= x_vld_q;
            if (start_acc) begin
                res_addr_o <= '0;
            end else if (res_we_o) begin
                res_addr_o <= res_addr_o + ADDR_W'(1);
            end
        end
    end

    npu_valid_dly #(
        .LAT (LAT)
    ) u_valid_dly (
        .clk    (wb_clk_i),
        .resetn (wb_rst_ni),
        .flush  (abort_act),
        .din    (en_o),
        .dout   (res_we_o)
    );

`ifdef NPU_SEQ_PERF_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            perf_cyc_o <= '0;
        end else if (start_acc) begin
            perf_cyc_o <= '0;
        end else if (busy_o && perf_cyc_o != 16'hFFFF) begin
            perf_cyc_o <= perf_cyc_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// tb/tb_npu_seq_ctrl.sv - self-checking bench for npu_seq_ctrl
module tb_npu_seq_ctrl;

    localparam int ROWS   = 4;
    localparam int ADDR_W = 8;
    localparam int LAT    = 7;

    logic              wb_clk_i  = 1'b0;
    logic              wb_rst_ni = 1'b0;
    logic              start_i   = 1'b0;
    logic              abort_i   = 1'b0;
    logic [ADDR_W-1:0] num_vec_i = '0;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] w_rd_addr_o;
    logic [ROWS-1:0]   w_load_o;
    logic [ADDR_W-1:0] x_rd_addr_o;
    logic              en_o;
    logic              res_we_o;
    logic [ADDR_W-1:0] res_addr_o;
`ifdef NPU_SEQ_PERF_EN
    logic [15:0]       perf_cyc_o;
`endif

    npu_seq_ctrl #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .LAT    (LAT)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .num_vec_i   (num_vec_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .w_rd_addr_o (w_rd_addr_o),
        .w_load_o    (w_load_o),
        .x_rd_addr_o (x_rd_addr_o),
        .en_o        (en_o),
        .res_we_o    (res_we_o),
        .res_addr_o  (res_addr_o)
`ifdef NPU_SEQ_PERF_EN
        ,
        .perf_cyc_o  (perf_cyc_o)
`endif
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance to the next rising edge; outputs are read 1 time unit later.
    task automatic tick();
        @(posedge wb_clk_i);
        cyc++;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"},   32'(busy_o),   0);
        chk({tag, ".done"},   32'(done_o),   0);
        chk({tag, ".w_load"}, 32'(w_load_o), 0);
        chk({tag, ".en"},     32'(en_o),     0);
        chk({tag, ".res_we"}, 32'(res_we_o), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk_quiet(tag);
        chk({tag, ".w_rd_addr"},  32'(w_rd_addr_o), 0);
        chk({tag, ".x_rd_addr"},  32'(x_rd_addr_o), 0);
        chk({tag, ".res_addr"},   32'(res_addr_o),  0);
    endtask

    // One operation started at the next edge T. Offsets are relative to T,
    // 0 means unused. Expected waveforms come from the timing rules:
    // busy T+1..Tdone, w_load[i] at T+2+i, en at T+ROWS+2+j,
    // res_we LAT later, done at T+ROWS+N+LAT+2.
    task automatic do_run(input int n, input int abort_off, input int rst_off, input int dup_off);
        int t;
        int t_done;
        int t_end;
        int kill;
        int busy_e;
        int done_e;
        int wl_e;
        int en_e;
        int we_e;
        t      = cyc + 1;
        t_done = t + ROWS + n + LAT + 2;
        t_end  = t_done + 2;
        kill   = (abort_off > 0) ? t + abort_off : ((rst_off > 0) ? t + rst_off : 0);
        start_i   = 1'b1;
        num_vec_i = ADDR_W'(n);
        for (int c = t; c <= t_end; c++) begin
            tick();
            start_i   = (dup_off > 0 && c + 1 == t + dup_off);
            abort_i   = (abort_off > 0 && c + 1 == t + abort_off);
            wb_rst_ni = !(rst_off > 0 && c + 1 == t + rst_off);
            num_vec_i = ADDR_W'($urandom);
            if (kill != 0 && c > kill) begin
                chk_zero("killed");
            end else if (kill == 0 || c < kill) begin
                busy_e = (c >= t + 1 && c <= t_done) ? 1 : 0;
                done_e = (c == t_done) ? 1 : 0;
                wl_e   = (c >= t + 2 && c <= t + ROWS + 1) ? (1 << (c - t - 2)) : 0;
                en_e   = (c >= t + ROWS + 2 && c <= t + ROWS + 1 + n) ? 1 : 0;
                we_e   = (c >= t + ROWS + 2 + LAT && c <= t + ROWS + 1 + n + LAT) ? 1 : 0;
                chk("busy",   32'(busy_o),   busy_e);
                chk("done",   32'(done_o),   done_e);
                chk("w_load", 32'(w_load_o), wl_e);
                chk("en",     32'(en_o),     en_e);
                chk("res_we", 32'(res_we_o), we_e);
                if (c >= t + 1 && c <= t + ROWS)
                    chk("w_rd_addr", 32'(w_rd_addr_o), c - t - 1);
                if (c >= t + ROWS + 1 && c <= t + ROWS + n)
                    chk("x_rd_addr", 32'(x_rd_addr_o), c - t - ROWS - 1);
                if (we_e != 0)
                    chk("res_addr", 32'(res_addr_o), c - (t + ROWS + 2 + LAT));
            end
        end
        start_i   = 1'b0;
        abort_i   = 1'b0;
        wb_rst_ni = 1'b1;
`ifdef NPU_SEQ_PERF_EN
        if (kill == 0)
            chk("perf_cyc", 32'(perf_cyc_o), t_done - t);
`endif
    endtask

    initial begin
        int n;
        int mode;
        wb_rst_ni = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        wb_rst_ni = 1'b1;
        repeat (2) tick();
        chk_zero("post_reset");

        do_run(3, 0, 0, 0);           // nominal
        do_run(0, 0, 0, 0);           // N = 0
        do_run(3, 0, 0, 4);           // start while busy is ignored
        do_run(3, 7, 0, 0);           // abort during STREAM
        tick();
        do_run(3, 0, 0, 0);           // restart after abort
        do_run(3, 0, 10, 0);          // reset mid-operation
        tick();

        // start and abort together in IDLE: abort wins
        start_i   = 1'b1;
        abort_i   = 1'b1;
        num_vec_i = ADDR_W'(5);
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_quiet("start_abort_idle");
        end

        // abort alone in IDLE has no effect on the next start
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk_quiet("abort_idle");

        do_run((1 << ADDR_W) - 1, 0, 0, 0);   // maximum N

        for (int r = 0; r < 8; r++) begin
            n    = $urandom_range(0, 20);
            mode = $urandom_range(0, 2);
            if (mode == 1)
                do_run(n, $urandom_range(1, ROWS + n + LAT + 2), 0, 0);
            else if (mode == 2)
                do_run(n, 0, $urandom_range(1, ROWS + n + LAT + 2), 0);
            else
                do_run(n, 0, 0, $urandom_range(0, ROWS + n + LAT + 2));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
